// File: rtl/decode_exec_if.sv
// Memory-side bus of the decode/execute stage: shared ROM/RAM address,
// fetch source select and the RAM read/write data path.
interface decode_exec_if;
  logic [7:0] address;
  logic       fetch_source;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  modport master (
    output address,
    output fetch_source,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  address,
    input  fetch_source,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/decode_exec.sv
// Control/execute stage of the 8-bit CPU: sequences FETCH/DECODE/EXEC/MEM,
// owns pc, accumulator and flags, and drives the ROM/RAM bus.
module decode_exec #(
  parameter int BITS       = 8,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS-1:0]       instr,
  output logic [STATE_BITS-1:0] state,
  output logic [BITS-1:0]       pc,
  output logic [BITS-1:0]       acc,
  output logic                  zero,
  output logic                  carry,
  output logic                  halted,
  decode_exec_if.master         bus
);

  typedef enum logic [STATE_BITS-1:0] {
    S_RESET  = STATE_BITS'(0),
    S_FETCH  = STATE_BITS'(1),
    S_DECODE = STATE_BITS'(2),
    S_EXEC   = STATE_BITS'(3),
    S_MEM    = STATE_BITS'(4),
    S_HALT   = STATE_BITS'(5)
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LD   = 3'd3,
    OP_ST   = 3'd4,
    OP_JMP  = 3'd5,
    OP_JZ   = 3'd6,
    OP_HLT  = 3'd7
  } op_t;

  state_t          state_q;
  op_t             op_q;
  logic [4:0]      imm_q;
  logic [BITS:0]   sum;
  logic [BITS-1:0] imm_ext;

  assign state   = state_q;
  assign imm_ext = BITS'(imm_q);
  assign sum     = {1'b0, acc} + {1'b0, imm_ext};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      pc      <= '0;
      acc     <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state_q)
        S_RESET:  state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= op_t'(instr[7:5]);
          imm_q   <= instr[4:0];
          pc      <= pc + 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (op_q)
            OP_LDI: begin
              acc   <= imm_ext;
              carry <= 1'b0;
              zero  <= (imm_ext == '0);
            end
            OP_ADDI: begin
              acc   <= sum[BITS-1:0];
              carry <= sum[BITS];
              zero  <= (sum[BITS-1:0] == '0);
            end
            OP_LD:  state_q <= S_MEM;
            OP_JMP: pc <= imm_ext;
            OP_JZ:  if (zero) pc <= imm_ext;
            OP_HLT: begin
              state_q <= S_HALT;
              halted  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          acc     <= BITS'(bus.mem_rdata);
          carry   <= 1'b0;
          zero    <= (bus.mem_rdata == '0);
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

  // LD keeps the RAM address and source through both EXEC and MEM.
  always_comb begin
    bus.address      = pc[7:0];
    bus.fetch_source = 1'b0;
    bus.mem_we       = 1'b0;
    if ((state_q == S_EXEC && op_q == OP_LD) || state_q == S_MEM) begin
      bus.address      = {3'b000, imm_q};
      bus.fetch_source = 1'b1;
    end else if (state_q == S_EXEC && op_q == OP_ST) begin
      bus.address = {3'b000, imm_q};
      bus.mem_we  = 1'b1;
    end
  end

  assign bus.mem_wdata = acc[7:0];

endmodule

// File: tb/tb_decode_exec.sv
// Bench for decode_exec: table-driven program with a completion scoreboard,
// plus hand-written reset, HALT and pc-wrap sequences.
module tb_decode_exec;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = '0;
  logic [2:0] state;
  logic [7:0] pc, acc;
  logic       zero, carry, halted;

  decode_exec_if bus();

  decode_exec #(.BITS(8), .STATE_BITS(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .state  (state),
    .pc     (pc),
    .acc    (acc),
    .zero   (zero),
    .carry  (carry),
    .halted (halted),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] ins;
    logic [7:0] acc;
    logic       z;
    logic       c;
    logic [7:0] pc;
    int         lat;
  } vec_t;

  logic [7:0] rom [256];
  logic [7:0] ram [256];
  vec_t       sbq [$];
  int         checks = 0;
  int         errors = 0;
  bit         sb_on = 1'b0;
  int         cyc = 0;
  int         fetch_start = 0;
  logic [2:0] prev_state = '0;
  int         we_cnt = 0;
  int         ld5_cnt = 0;
  int         src_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_for(input logic [2:0] st, input logic [7:0] p, input int maxc, input string nm);
    int n = 0;
    while (!(state == st && pc == p) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, (state == st && pc == p)}, 32'd1);
  endtask

  // Fetcher/RAM model and scoreboard monitor, all on the falling edge.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (state == 3'd1 && !bus.fetch_source) instr = rom[bus.address];
      if (bus.mem_we) ram[bus.address] = bus.mem_wdata;
      bus.mem_rdata = bus.fetch_source ? ram[bus.address] : 8'h00;
      if (sb_on) begin
        if (state == 3'd1 && prev_state == 3'd0) fetch_start = cyc;
        if (state == 3'd1 && (prev_state == 3'd3 || prev_state == 3'd4)) begin
          if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            vec_t e;
            e = sbq.pop_front();
            check("sb_acc", acc, e.acc);
            check("sb_zero", zero, e.z);
            check("sb_carry", carry, e.c);
            check("sb_pc", pc, e.pc);
            check("sb_latency", cyc - fetch_start, e.lat);
          end
          fetch_start = cyc;
        end
        if (bus.mem_we) begin
          we_cnt++;
          check("st_address", bus.address, 8'd5);
          check("st_wdata", bus.mem_wdata, 8'd7);
        end
        if (bus.fetch_source) src_cnt++;
        if (bus.fetch_source && bus.address == 8'd5) ld5_cnt++;
      end
      prev_state = state;
    end
  end

  initial begin
    vec_t prog [14];
    logic [7:0] hold_pc, hold_acc;

    prog = '{
      '{8'd0,  8'h3F, 8'h1F, 1'b0, 1'b0, 8'd1,  3},  // LDI 31
      '{8'd1,  8'h5F, 8'h3E, 1'b0, 1'b0, 8'd2,  3},  // ADDI 31
      '{8'd2,  8'h74, 8'hF0, 1'b0, 1'b0, 8'd3,  4},  // LD 20
      '{8'd3,  8'h50, 8'h00, 1'b1, 1'b1, 8'd4,  3},  // ADDI 16
      '{8'd4,  8'hCA, 8'h00, 1'b1, 1'b1, 8'd10, 3},  // JZ 10 taken
      '{8'd10, 8'h41, 8'h01, 1'b0, 1'b0, 8'd11, 3},  // ADDI 1
      '{8'd11, 8'hC3, 8'h01, 1'b0, 1'b0, 8'd12, 3},  // JZ 3 not taken
      '{8'd12, 8'h27, 8'h07, 1'b0, 1'b0, 8'd13, 3},  // LDI 7
      '{8'd13, 8'h85, 8'h07, 1'b0, 1'b0, 8'd14, 3},  // ST 5
      '{8'd14, 8'h20, 8'h00, 1'b1, 1'b0, 8'd15, 3},  // LDI 0
      '{8'd15, 8'h65, 8'h07, 1'b0, 1'b0, 8'd16, 4},  // LD 5
      '{8'd16, 8'h00, 8'h07, 1'b0, 1'b0, 8'd17, 3},  // NOP
      '{8'd17, 8'hBE, 8'h07, 1'b0, 1'b0, 8'd30, 3},  // JMP 30
      '{8'd30, 8'h5F, 8'h26, 1'b0, 1'b0, 8'd31, 3}   // ADDI 31
    };

    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00;
      ram[i] = 8'h00;
    end
    ram[20] = 8'hF0;
    for (int i = 0; i < 14; i++) begin
      rom[prog[i].addr] = prog[i].ins;
      sbq.push_back(prog[i]);
    end
    rom[31] = 8'hE0;  // HLT

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 8'd0);
    check("rst_acc", acc, 8'd0);
    check("rst_flags", {zero, carry}, 2'b00);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_halted", halted, 1'b0);

    sb_on = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("first_fetch", state, 3'd1);

    wait_for(3'd5, 8'd32, 300, "reach_halt");
    check("halted_flag", halted, 1'b1);
    check("halt_acc", acc, 8'h26);
    check("sb_drained", sbq.size(), 0);
    check("st_pulse_count", we_cnt, 1);
    check("ld5_cycles", ld5_cnt, 2);
    check("ld_src_cycles", src_cnt, 4);
    check("ram5", ram[5], 8'd7);

    hold_pc  = pc;
    hold_acc = acc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_pc", pc, hold_pc);
      check("halt_acc_frozen", acc, hold_acc);
      check("halt_we", bus.mem_we, 1'b0);
      check("halt_state", state, 3'd5);
    end
    sb_on = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("halt_rst_halted", halted, 1'b0);
    check("halt_rst_pc", pc, 8'd0);
    check("halt_rst_state", state, 3'd0);

    // Reset mid-EXEC of ADDI with acc=0x20
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h30;  // LDI 16
    rom[1] = 8'h50;  // ADDI 16
    rom[2] = 8'h41;  // ADDI 1
    reset = 1'b0;
    wait_for(3'd3, 8'd3, 50, "reach_exec_addi");
    check("pre_rst_acc", acc, 8'h20);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_pc", pc, 8'd0);
    check("mid_rst_acc", acc, 8'd0);
    check("mid_rst_flags", {zero, carry}, 2'b00);
    check("mid_rst_we", bus.mem_we, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_fetch", state, 3'd1);

    // NOP at pc=255 wraps to 0
    reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    wait_for(3'd2, 8'd255, 1000, "reach_nop255");
    repeat (2) @(negedge clk);
    check("nop_wrap_state", state, 3'd1);
    check("nop_wrap_pc", pc, 8'd0);

    // JMP 3 at pc=255
    reset = 1'b1;
    rom[255] = 8'hA3;
    @(negedge clk);
    reset = 1'b0;
    wait_for(3'd2, 8'd255, 1000, "reach_jmp255");
    repeat (2) @(negedge clk);
    check("jmp_wrap_state", state, 3'd1);
    check("jmp_wrap_pc", pc, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
